// File: rtl/multicycle_controller.sv
// multicycle_controller: multi-cycle RV32I control FSM sequencing fetch/decode/execute/memory/writeback
// over a shared ALU and unified memory, with memory wait states, optional MDU stall, trap and retire count.
module multicycle_controller #(
    parameter bit MEM_WAIT = 1'b1,
    parameter bit ENABLE_M = 1'b0,
    parameter int CNT_W    = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [6:0]       op,
    input  logic [2:0]       funct3,
    input  logic [6:0]       funct7,
    input  logic             zero,
    input  logic             alu_lsb,
    input  logic             mem_ready,
    input  logic             mdu_done,
    output logic             pc_write,
    output logic             ir_write,
    output logic             adr_src,
    output logic             mem_req,
    output logic             mem_write,
    output logic             reg_write,
    output logic [1:0]       result_src,
    output logic [1:0]       alu_src_a,
    output logic [1:0]       alu_src_b,
    output logic [3:0]       alu_control,
    output logic [2:0]       imm_src,
    output logic             mdu_start,
    output logic             illegal_instr,
    output logic [CNT_W-1:0] instret
);
    typedef enum logic [4:0] {
        S_START, S_FETCH, S_DECODE, S_MEMADR, S_MEMREAD, S_MEMWB, S_MEMWRITE,
        S_EXEC_R, S_EXEC_I, S_ALUWB, S_BRANCH, S_JAL, S_JALR_ADR, S_JALR_PC,
        S_UPPER, S_EXEC_M, S_MDU_WAIT, S_TRAP
    } state_t;
    state_t           r_state, w_next;
    logic             r_illegal, r_from_mdu;
    logic [CNT_W-1:0] r_instret;
    logic             w_ready, w_mop, w_f7_std, w_shift, w_taken;
    logic [3:0]       w_alu_fn, w_br_alu;
    logic [2:0]       w_imm;
    assign w_ready  = MEM_WAIT ? mem_ready : 1'b1;
    assign w_mop    = ENABLE_M && funct7 == 7'b0000001;
    assign w_f7_std = funct7 == 7'b0000000 || funct7 == 7'b0100000;
    assign w_shift  = funct3 == 3'b001 || funct3 == 3'b101;
    assign w_br_alu = !funct3[2] ? 4'b0001 : funct3[1] ? 4'b0110 : 4'b0101;
    assign w_taken  = funct3[2:1] == 2'b00 ? zero ^ funct3[0] :
                      funct3[2]            ? alu_lsb ^ funct3[0] : 1'b0;
    assign w_imm    = op == 7'b0100011 ? 3'b001 :
                      op == 7'b1100011 ? 3'b010 :
                      (op == 7'b0110111 || op == 7'b0010111) ? 3'b011 :
                      op == 7'b1101111 ? 3'b100 : 3'b000;
    assign illegal_instr = r_illegal;
    assign instret       = r_instret;
    always_comb begin
        w_alu_fn = 4'b0000;
        case (funct3)
            3'b000:  w_alu_fn = (r_state == S_EXEC_R && funct7[5]) ? 4'b0001 : 4'b0000;
            3'b001:  w_alu_fn = 4'b0111;
            3'b010:  w_alu_fn = 4'b0101;
            3'b011:  w_alu_fn = 4'b0110;
            3'b100:  w_alu_fn = 4'b0100;
            3'b101:  w_alu_fn = funct7[5] ? 4'b1001 : 4'b1000;
            3'b110:  w_alu_fn = 4'b0011;
            default: w_alu_fn = 4'b0010;
        endcase
    end
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_START:    w_next = S_FETCH;
            S_FETCH:    w_next = w_ready ? S_DECODE : S_FETCH;
            S_DECODE:
                case (op)
                    7'b0000011, 7'b0100011: w_next = S_MEMADR;
                    7'b0110011:             w_next = w_mop ? S_EXEC_M : S_EXEC_R;
                    7'b0010011:             w_next = S_EXEC_I;
                    7'b1100011:             w_next = S_BRANCH;
                    7'b1101111:             w_next = S_JAL;
                    7'b1100111:             w_next = S_JALR_ADR;
                    7'b0110111, 7'b0010111: w_next = S_UPPER;
                    default:                w_next = S_TRAP;
                endcase
            S_MEMADR:   w_next = op[5] ? S_MEMWRITE : S_MEMREAD;
            S_MEMREAD:  w_next = w_ready ? S_MEMWB : S_MEMREAD;
            S_MEMWB:    w_next = S_FETCH;
            S_MEMWRITE: w_next = w_ready ? S_FETCH : S_MEMWRITE;
            S_EXEC_R:   w_next = w_f7_std ? S_ALUWB : S_TRAP;
            S_EXEC_I:   w_next = (w_shift && !w_f7_std) ? S_TRAP : S_ALUWB;
            S_ALUWB:    w_next = S_FETCH;
            S_BRANCH:   w_next = funct3[2:1] == 2'b01 ? S_TRAP : S_FETCH;
            S_JAL:      w_next = S_ALUWB;
            S_JALR_ADR: w_next = S_JALR_PC;
            S_JALR_PC:  w_next = S_ALUWB;
            S_UPPER:    w_next = S_ALUWB;
            S_EXEC_M:   w_next = S_MDU_WAIT;
            S_MDU_WAIT: w_next = mdu_done ? S_ALUWB : S_MDU_WAIT;
            S_TRAP:     w_next = S_TRAP;
            default:    w_next = S_START;
        endcase
    end
    // imm_src tracks the instruction whenever operand B selects the immediate
    always_comb begin
        pc_write    = 1'b0;
        ir_write    = 1'b0;
        adr_src     = 1'b0;
        mem_req     = 1'b0;
        mem_write   = 1'b0;
        reg_write   = 1'b0;
        result_src  = 2'b00;
        alu_src_a   = 2'b00;
        alu_src_b   = 2'b00;
        alu_control = 4'b0000;
        imm_src     = 3'b000;
        mdu_start   = 1'b0;
        case (r_state)
            S_FETCH:    {mem_req, alu_src_b, result_src, ir_write, pc_write} = {1'b1, 2'b10, 2'b10, w_ready, w_ready};
            S_DECODE:   {alu_src_a, alu_src_b, imm_src} = {2'b01, 2'b01, w_imm};
            S_MEMADR:   {alu_src_a, alu_src_b, imm_src} = {2'b10, 2'b01, w_imm};
            S_MEMREAD:  {mem_req, adr_src} = 2'b11;
            S_MEMWB:    {result_src, reg_write} = {2'b01, 1'b1};
            S_MEMWRITE: {mem_req, mem_write, adr_src} = 3'b111;
            S_EXEC_R:   {alu_src_a, alu_control} = {2'b10, w_alu_fn};
            S_EXEC_I:   {alu_src_a, alu_src_b, alu_control, imm_src} = {2'b10, 2'b01, w_alu_fn, w_imm};
            S_ALUWB:    {result_src, reg_write} = {r_from_mdu ? 2'b11 : 2'b00, 1'b1};
            S_BRANCH:   {alu_src_a, alu_control, pc_write} = {2'b10, w_br_alu, w_taken};
            S_JAL:      {alu_src_a, alu_src_b, pc_write} = {2'b01, 2'b10, 1'b1};
            S_JALR_ADR: {alu_src_a, alu_src_b, imm_src} = {2'b10, 2'b01, w_imm};
            S_JALR_PC:  {alu_src_a, alu_src_b, pc_write} = {2'b01, 2'b10, 1'b1};
            S_UPPER:    {alu_src_a, alu_src_b, imm_src} = {op[5] ? 2'b11 : 2'b01, 2'b01, w_imm};
            S_EXEC_M:   mdu_start = 1'b1;
            default:    mdu_start = 1'b0;
        endcase
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_START;
            r_illegal  <= 1'b0;
            r_from_mdu <= 1'b0;
            r_instret  <= '0;
        end else begin
            r_state    <= w_next;
            r_from_mdu <= r_state == S_MDU_WAIT;
            if (w_next == S_TRAP)
                r_illegal <= 1'b1;
            if (w_next == S_FETCH && r_state != S_FETCH && r_state != S_START)
                r_instret <= r_instret + CNT_W'(1);
        end
    end
endmodule

// File: tb/tb_multicycle_controller.sv
// tb_multicycle_controller: builds per-instruction expected output traces and checks the controller every cycle.
module tb_multicycle_controller;
    logic       clk = 1'b0, rst_n = 1'b0;
    logic [6:0] op = '0, funct7 = '0;
    logic [2:0] funct3 = '0;
    logic       zero = 1'b0, alu_lsb = 1'b0, mem_ready = 1'b0, mdu_done = 1'b0;
    logic       pc_write, ir_write, adr_src, mem_req, mem_write, reg_write, mdu_start, illegal_instr;
    logic [1:0] result_src, alu_src_a, alu_src_b;
    logic [3:0] alu_control, instret;
    logic [2:0] imm_src;

    multicycle_controller #(.MEM_WAIT(1'b1), .ENABLE_M(1'b1), .CNT_W(4)) dut (
        .clk(clk), .rst_n(rst_n), .op(op), .funct3(funct3), .funct7(funct7), .zero(zero),
        .alu_lsb(alu_lsb), .mem_ready(mem_ready), .mdu_done(mdu_done), .pc_write(pc_write),
        .ir_write(ir_write), .adr_src(adr_src), .mem_req(mem_req), .mem_write(mem_write),
        .reg_write(reg_write), .result_src(result_src), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
        .alu_control(alu_control), .imm_src(imm_src), .mdu_start(mdu_start),
        .illegal_instr(illegal_instr), .instret(instret)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1);
    end

    typedef struct {
        logic [6:0]  op;
        logic [2:0]  f3;
        logic [6:0]  f7;
        logic        z, l, r, d;
        logic [20:0] e;
        logic [3:0]  n;
    } rec_t;

    rec_t       q[$];
    int         total = 0, bad = 0, step = 0;
    logic [3:0] retired = '0;
    logic       ill = 1'b0;
    logic [6:0] c_op = '0, c_f7 = '0;
    logic [2:0] c_f3 = '0;
    localparam int ADD = 0, SUB = 1, SLT = 5, SLTU = 6, SRA = 9;

    wire [20:0] w_out = {pc_write, ir_write, adr_src, mem_req, mem_write, reg_write, result_src,
                         alu_src_a, alu_src_b, alu_control, imm_src, mdu_start, illegal_instr};

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    function automatic logic [19:0] ev(input int pcw, irw, adr, req, wr, rw, rs, a, b, alu, imm, st);
        return {pcw[0], irw[0], adr[0], req[0], wr[0], rw[0], rs[1:0], a[1:0], b[1:0], alu[3:0], imm[2:0], st[0]};
    endfunction

    task automatic push(input int z, l, r, d, input logic [19:0] e);
        q.push_back('{op: c_op, f3: c_f3, f7: c_f7, z: z[0], l: l[0], r: r[0], d: d[0], e: {e, ill}, n: retired});
    endtask

    task automatic retire();
        retired = retired + 4'd1;
    endtask

    task automatic start();
        push(0, 0, 0, 0, '0);
    endtask

    task automatic fetch(input int w);
        for (int i = 0; i < w; i++) push(0, 0, 0, 0, ev(0, 0, 0, 1, 0, 0, 2, 0, 2, ADD, 0, 0));
        push(0, 0, 1, 0, ev(1, 1, 0, 1, 0, 0, 2, 0, 2, ADD, 0, 0));
    endtask

    task automatic decode(input int imm);
        push(0, 0, 0, 0, ev(0, 0, 0, 0, 0, 0, 0, 1, 1, ADD, imm, 0));
    endtask

    task automatic wb(input int rs);
        push(0, 0, 0, 0, ev(0, 0, 0, 0, 0, 1, rs, 0, 0, ADD, 0, 0));
    endtask

    task automatic setop(input int o, f3, f7);
        c_op = o[6:0];
        c_f3 = f3[2:0];
        c_f7 = f7[6:0];
    endtask

    task automatic alu_r(input int f3, f7, alu);
        setop('b0110011, f3, f7);
        fetch(0);
        decode(0);
        push(0, 0, 0, 0, ev(0, 0, 0, 0, 0, 0, 0, 2, 0, alu, 0, 0));
        wb(0);
        retire();
    endtask

    task automatic alu_i(input int f3, f7, alu, fw);
        setop('b0010011, f3, f7);
        fetch(fw);
        decode(0);
        push(0, 0, 0, 0, ev(0, 0, 0, 0, 0, 0, 0, 2, 1, alu, 0, 0));
        wb(0);
        retire();
    endtask

    task automatic load(input int w);
        setop('b0000011, 2, 0);
        fetch(0);
        decode(0);
        push(0, 0, 0, 0, ev(0, 0, 0, 0, 0, 0, 0, 2, 1, ADD, 0, 0));
        for (int i = 0; i < w; i++) push(0, 0, 0, 0, ev(0, 0, 1, 1, 0, 0, 0, 0, 0, ADD, 0, 0));
        push(0, 0, 1, 0, ev(0, 0, 1, 1, 0, 0, 0, 0, 0, ADD, 0, 0));
        push(0, 0, 0, 0, ev(0, 0, 0, 0, 0, 1, 1, 0, 0, ADD, 0, 0));
        retire();
    endtask

    task automatic store(input int w, input bit fin);
        setop('b0100011, 2, 0);
        fetch(0);
        decode(1);
        push(0, 0, 0, 0, ev(0, 0, 0, 0, 0, 0, 0, 2, 1, ADD, 1, 0));
        for (int i = 0; i < w; i++) push(0, 0, 0, 0, ev(0, 0, 1, 1, 1, 0, 0, 0, 0, ADD, 0, 0));
        if (fin) begin
            push(0, 0, 1, 0, ev(0, 0, 1, 1, 1, 0, 0, 0, 0, ADD, 0, 0));
            retire();
        end
    endtask

    task automatic branch(input int f3, z, l, alu, tk);
        setop('b1100011, f3, 0);
        fetch(0);
        decode(2);
        push(z, l, 0, 0, ev(tk, 0, 0, 0, 0, 0, 0, 2, 0, alu, 0, 0));
        retire();
    endtask

    task automatic mul(input int stalls);
        setop('b0110011, 0, 1);
        fetch(0);
        push(0, 0, 0, 1, ev(0, 0, 0, 0, 0, 0, 0, 1, 1, ADD, 0, 0));
        push(0, 0, 0, 0, ev(0, 0, 0, 0, 0, 0, 0, 0, 0, ADD, 0, 1));
        for (int i = 0; i < stalls; i++) push(0, 0, 1, i == stalls - 1, '0);
        wb(3);
        retire();
    endtask

    task automatic jal();
        setop('b1101111, 0, 0);
        fetch(0);
        decode(4);
        push(0, 0, 0, 0, ev(1, 0, 0, 0, 0, 0, 0, 1, 2, ADD, 0, 0));
        wb(0);
        retire();
    endtask

    task automatic upper(input bit lui);
        setop(lui ? 'b0110111 : 'b0010111, 0, 0);
        fetch(0);
        decode(3);
        push(0, 0, 0, 0, ev(0, 0, 0, 0, 0, 0, 0, lui ? 3 : 1, 1, ADD, 3, 0));
        wb(0);
        retire();
    endtask

    task automatic jalr();
        setop('b1100111, 0, 0);
        fetch(0);
        decode(0);
        push(0, 0, 0, 0, ev(0, 0, 0, 0, 0, 0, 0, 2, 1, ADD, 0, 0));
        push(0, 0, 0, 0, ev(1, 0, 0, 0, 0, 0, 0, 1, 2, ADD, 0, 0));
        wb(0);
        retire();
    endtask

    task automatic run();
        while (q.size() > 0) begin
            rec_t c = q.pop_front();
            {op, funct3, funct7} = {c.op, c.f3, c.f7};
            {zero, alu_lsb, mem_ready, mdu_done} = {c.z, c.l, c.r, c.d};
            step++;
            #3;
            check($sformatf("cyc%0d_out", step), 32'(w_out), 32'(c.e));
            check($sformatf("cyc%0d_instret", step), 32'(instret), 32'(c.n));
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;
        check("reset_out", 32'(w_out), 32'd0);
        check("reset_instret", 32'(instret), 32'd0);
        rst_n = 1'b1;
        start();
        alu_r(0, 0, ADD);
        run();
        check("add_retired", 32'(instret), 32'd1);
        load(3);
        branch(0, 1, 0, SUB, 1);
        branch(5, 0, 1, SLT, 0);
        run();
        check("branches_retired", 32'(instret), 32'd4);
        mul(5);
        jal();
        upper(1'b1);
        upper(1'b0);
        jalr();
        alu_i(5, 'b0100000, SRA, 0);
        alu_r(0, 'b0100000, SUB);
        store(2, 1'b1);
        alu_r(3, 0, SLTU);
        alu_i(0, 0, ADD, 1);
        alu_i(0, 0, ADD, 0);
        alu_i(0, 0, ADD, 0);
        run();
        check("instret_wrap", 32'(instret), 32'd0);
        store(2, 1'b0);
        run();
        check("sw_wait_memwrite", 32'(mem_write), 32'd1);
        rst_n = 1'b0;
        #1;
        check("sw_reset_memwrite", 32'(mem_write), 32'd0);
        check("sw_reset_memreq", 32'(mem_req), 32'd0);
        retired = '0;
        ill = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        start();
        setop(0, 0, 0);
        fetch(0);
        decode(0);
        ill = 1'b1;
        push(1, 1, 1, 1, '0);
        push(0, 0, 1, 0, '0);
        push(0, 0, 0, 1, '0);
        push(1, 0, 1, 1, '0);
        run();
        check("trap_sticky", 32'(illegal_instr), 32'd1);
        rst_n = 1'b0;
        #1;
        check("trap_reset_clear", 32'(illegal_instr), 32'd0);
        check("trap_reset_out", 32'(w_out), 32'd0);
        #10;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
